// File: rtl/if_id_queue.sv
// Decoupled IF/ID boundary: a DEPTH-entry FIFO of (PC, instruction) pairs between
// fetch and decode. It has valid/ready on both sides, a synchronous flush and a bubble flag.
module if_id_queue #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     ILEN      = 32,
  parameter int unsigned     DEPTH     = 4,
  parameter logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     if_valid,
  output logic                     if_ready,
  input  logic [XLEN-1:0]          pc_if,
  input  logic [ILEN-1:0]          instr_if,
  output logic                     id_valid,
  input  logic                     id_ready,
  output logic [XLEN-1:0]          pc_id,
  output logic [ILEN-1:0]          instr_id,
  output logic                     bubble_id,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = XLEN + ILEN;

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_c, empty_c, push_c, pop_c, mem_we_c;
  logic [ENT_W-1:0] head_c;

  // Handshakes depend only on the registered occupancy. Flush overrides push and pop.
  always_comb begin
    full_c   = (count_q == CNT_W'(DEPTH));
    empty_c  = (count_q == '0);
    push_c   = if_valid & ~full_c;
    pop_c    = id_ready & ~empty_c;
    mem_we_c = push_c & ~flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage is deliberately left unreset; the pointers and count qualify it.
  always_ff @(posedge clk) begin
    if (mem_we_c) mem_q[wr_ptr_q] <= {pc_if, instr_if};
  end

  always_comb begin
    head_c    = mem_q[rd_ptr_q];
    if_ready  = ~full_c;
    id_valid  = ~empty_c;
    bubble_id = empty_c;
    pc_id     = empty_c ? '0 : head_c[ENT_W-1:ILEN];
    instr_id  = empty_c ? NOP_INSTR : head_c[ILEN-1:0];
    count     = count_q;
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue. It runs directed scenarios and then random traffic. Every cycle
// the DUT is compared against a queue-based model of the FIFO.
module tb_if_id_queue;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned ILEN  = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic            clk = 1'b0;
  logic            reset, flush, if_valid, id_ready;
  logic [XLEN-1:0] pc_if, pc_id;
  logic [ILEN-1:0] instr_if, instr_id;
  logic            if_ready, id_valid, bubble_id;
  logic [2:0]      count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] model_q [$];
  logic [31:0] pop_log [$];

  if_id_queue #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .if_valid(if_valid), .if_ready(if_ready), .pc_if(pc_if), .instr_if(instr_if),
    .id_valid(id_valid), .id_ready(id_ready), .pc_id(pc_id), .instr_id(instr_id),
    .bubble_id(bubble_id), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a plain FIFO of {pc, instr}.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_q.delete();
    end else if (flush) begin
      model_q.delete();
    end else begin
      automatic bit do_push = if_valid && (model_q.size() < DEPTH);
      automatic bit do_pop  = id_ready && (model_q.size() > 0);
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back({pc_if, instr_if});
    end
  end

  // The outputs depend only on state, so they are compared mid-cycle, away from the edge.
  always @(negedge clk) begin
    automatic bit          emp = (model_q.size() == 0);
    automatic logic [63:0] hd  = emp ? {32'h0, NOP} : model_q[0];
    chk("count",     64'(count),     64'(model_q.size()));
    chk("id_valid",  64'(id_valid),  64'(!emp));
    chk("bubble_id", 64'(bubble_id), 64'(emp));
    chk("if_ready",  64'(if_ready),  64'(model_q.size() < DEPTH));
    chk("pc_id",     64'(pc_id),     64'(hd[63:32]));
    chk("instr_id",  64'(instr_id),  64'(hd[31:0]));
  end

  // Apply one cycle of inputs, log handshakes, and stop just after the edge.
  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic rdy, input logic fl, output bit acc);
    if_valid = v; pc_if = pc; instr_if = ins; id_ready = rdy; flush = fl;
    #0;
    acc = v && if_ready && !fl;
    if (id_valid && rdy && !fl) pop_log.push_back(pc_id);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    if_valid = 0; id_ready = 0; flush = 0; pc_if = '0; instr_if = '0;
    reset = 1'b1;
    #3;
    reset = 1'b0;
    pop_log.delete();
  endtask

  // Fetch stream: sequential PCs up to lim, advancing only when accepted.
  task automatic fetch(inout logic [31:0] npc, input logic [31:0] lim, input logic rdy);
    bit acc;
    drive(npc <= lim, npc, npc ^ 32'hA5A5_0000, rdy, 1'b0, acc);
    if (acc) npc += 4;
  endtask

  initial begin
    bit acc;
    logic [31:0] npc;
    reset = 1'b1;
    do_reset();
    @(posedge clk); #1;

    // Two pushes with decode stalled.
    drive(1, 32'h100, 32'hA, 0, 0, acc);
    drive(1, 32'h104, 32'hB, 0, 0, acc);
    if_valid = 0;
    chk("t1_count", 64'(count), 64'd2);
    chk("t1_pc", 64'(pc_id), 64'h100);
    chk("t1_instr", 64'(instr_id), 64'hA);
    chk("t1_if_ready", 64'(if_ready), 64'd1);

    // Fill past capacity, then drain across the pointer wrap.
    do_reset();
    npc = 32'h100;
    for (int i = 0; i < 5; i++) fetch(npc, 32'h110, 0);
    chk("t2_count_full", 64'(count), 64'd4);
    chk("t2_if_ready", 64'(if_ready), 64'd0);
    chk("t2_held_pc", 64'(npc), 64'h110);
    for (int i = 0; i < 8; i++) fetch(npc, 32'h110, 1);
    chk("t2_pops", 64'(pop_log.size()), 64'd5);
    for (int i = 0; i < pop_log.size(); i++)
      chk("t2_order", 64'(pop_log[i]), 64'(32'h100 + 32'(4 * i)));
    chk("t2_count_end", 64'(count), 64'd0);

    // Steady state: one push and one pop per cycle at count 2.
    do_reset();
    npc = 32'h300;
    for (int i = 0; i < 2; i++) fetch(npc, 32'hFFFF, 0);
    for (int i = 0; i < 10; i++) begin
      fetch(npc, 32'hFFFF, 1);
      chk("t3_count", 64'(count), 64'd2);
    end
    chk("t3_pops", 64'(pop_log.size()), 64'd10);
    for (int i = 0; i < pop_log.size(); i++)
      chk("t3_seq", 64'(pop_log[i]), 64'(32'h300 + 32'(4 * i)));

    // A flush with a concurrent push and pop.
    do_reset();
    npc = 32'h400;
    for (int i = 0; i < 3; i++) fetch(npc, 32'hFFFF, 0);
    drive(1, 32'h40C, 32'hDEAD, 1, 1, acc);
    if_valid = 0; flush = 0; id_ready = 0;
    chk("t4_count", 64'(count), 64'd0);
    chk("t4_bubble", 64'(bubble_id), 64'd1);
    chk("t4_instr", 64'(instr_id), 64'h13);
    chk("t4_pc", 64'(pc_id), 64'h0);
    drive(0, 0, 0, 1, 0, acc);
    drive(1, 32'h500, 32'hE, 0, 0, acc);
    chk("t4_post_pc", 64'(pc_id), 64'h500);
    chk("t4_post_count", 64'(count), 64'd1);

    // An asynchronous reset in the middle of a cycle.
    do_reset();
    npc = 32'h700;
    for (int i = 0; i < 3; i++) fetch(npc, 32'hFFFF, 0);
    if_valid = 0;
    #2;
    reset = 1'b1;
    #1;
    chk("t5_id_valid", 64'(id_valid), 64'd0);
    chk("t5_count", 64'(count), 64'd0);
    chk("t5_if_ready", 64'(if_ready), 64'd1);
    chk("t5_instr", 64'(instr_id), 64'h13);
    reset = 1'b0;
    drive(1, 32'h200, 32'hC, 0, 0, acc);
    chk("t5_pc", 64'(pc_id), 64'h200);
    chk("t5_instr_c", 64'(instr_id), 64'hC);

    // Pops requested while empty must not underflow.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 1, 0, acc);
      chk("t6_count", 64'(count), 64'd0);
    end
    drive(1, 32'h600, 32'h1, 0, 0, acc);
    chk("t6_head", 64'(pc_id), 64'h600);
    drive(1, 32'h604, 32'h2, 1, 0, acc);
    chk("t6_head2", 64'(pc_id), 64'h604);
    chk("t6_count2", 64'(count), 64'd1);

    // Random traffic, checked only by the reference queue.
    do_reset();
    for (int i = 0; i < 3000; i++)
      drive($urandom_range(0, 3) != 0, $urandom, $urandom, 1'($urandom),
            $urandom_range(0, 31) == 0, acc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Parametrised, decoupled IF/ID boundary: a DEPTH-entry FIFO carrying (PC, instruction) pairs from fetch to decode with valid/ready handshakes on both sides. It replaces the single-entry stall/flush register, so fetch can run ahead of a stalled decode. It also adds a synchronous flush that empties all entries, an occupancy count and a bubble flag toward ID. It sits between the fetch unit and the decoder; the hazard unit drives flush.

## Interface
- XLEN, 32, PC width
- ILEN, 32, instruction width
- DEPTH, 4, number of entries; power of two, ≥ 2
- NOP_INSTR, 32'h00000013, value presented on instr_id when the queue is empty
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all control state immediately
- flush  input  1  synchronous discard of all entries at the next edge
- if_valid  input  1  fetch presents a (pc_if, instr_if) pair
- if_ready  output  1  queue can accept; equals !full
- pc_if  input  XLEN  PC of fetched instruction
- instr_if  input  ILEN  fetched instruction
- id_valid  output  1  head entry is valid; equals !empty
- id_ready  input  1  decode consumes the head this cycle (the inverse of the old stall)
- pc_id  output  XLEN  head PC; 0 when empty
- instr_id  output  ILEN  head instruction; NOP_INSTR when empty
- bubble_id  output  1  equals !id_valid; decode treats the slot as a bubble
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH

## Operation
- Storage: DEPTH×(XLEN+ILEN) array, not reset. Write pointer and read pointer are each $clog2(DEPTH) bits and wrap modulo DEPTH. count is a separate register.
- push = if_valid & if_ready; pop = id_valid & id_ready.
- On push: write the pair at wr_ptr and increment wr_ptr.
- On pop: increment rd_ptr.
- count update: count += push − pop. Push and pop in the same cycle leave count unchanged.
- Full (count == DEPTH): if_ready = 0, so no push, even if a pop occurs in that cycle. There is no pass-through when full.
- Empty (count == 0): id_valid = 0, bubble_id = 1, pc_id = 0, instr_id = NOP_INSTR. id_ready is ignored.
- Outputs pc_id/instr_id are a combinational read of array[rd_ptr], muxed to the empty values. There is no same-cycle bypass from pc_if to pc_id.
- Flush has priority over push and pop. At the edge where flush = 1:
  - count, wr_ptr and rd_ptr go to 0.
  - The push and pop of that cycle have no effect.
  - if_ready and id_valid still show their pre-edge values during the flush cycle; fetch must not treat a push in that cycle as accepted.
- Reset, asynchronous: count = 0, wr_ptr = rd_ptr = 0. Hence id_valid = 0, bubble_id = 1, if_ready = 1, pc_id = 0, instr_id = NOP_INSTR, all immediately without waiting for a clock edge. Reset dominates flush. Reset mid-stream discards all entries.
- Pointer wrap: the pointer after DEPTH−1 is 0; order is preserved across the wrap.

## Timing
- Fill latency: a pair pushed at edge N is on pc_id/instr_id with id_valid = 1 from edge N until it is popped. With an empty queue this is one cycle from presentation.
- Throughput: 1 push and 1 pop per cycle sustained when 0 < count < DEPTH.
- if_ready and id_valid depend only on registered count. There is no combinational path from id_ready to if_ready or from if_valid to id_valid.
- After a flush edge: count = 0 and bubble_id = 1 for at least one cycle. The earliest new entry appears one edge after a post-flush push.
- Reset deassertion: the first push is accepted on the first rising edge with reset low.

## Test plan
- Reset, then push pairs (0x100,0xA), (0x104,0xB) with id_ready = 0 → count = 2, pc_id = 0x100, instr_id = 0xA, if_ready = 1.
- DEPTH = 4: push 5 pairs with id_ready = 0 → 4 accepted, if_ready = 0 after the 4th, the 5th is held. Then hold id_ready = 1 and if_valid = 1 for 8 cycles → pops in order 0x100..0x10C, then the 5th pair. count never exceeds 4, and pointers wrap with no reordering.
- Push and pop simultaneously every cycle at count = 2 for 10 cycles → count stays 2, and output PCs are strictly sequential with step 4.
- Flush at count = 3 while if_valid = 1 and id_ready = 1 → next cycle count = 0, bubble_id = 1, instr_id = 0x00000013, pc_id = 0. Neither the flushed-cycle push nor a stale entry ever appears.
- Assert reset asynchronously mid-cycle at count = 3 → id_valid = 0 and count = 0 before the next clock edge. After release, pushing (0x200,0xC) gives pc_id = 0x200 one edge later.
- Empty queue with id_ready = 1 and no push for 5 cycles → count stays 0, there is no underflow, and rd_ptr is unchanged.
